// File: rtl/tank_hit_manager.sv
// Per-frame bullet/bullet and bullet/tank collision resolver with health, immunity windows
// and the PLAY/OVER game-state machine; every output is registered on frame_clk.
module tank_hit_manager #(
   parameter int START_HEALTH  = 3,
   parameter int HEALTH_W      = 2,
   parameter int INVULN_FRAMES = 60,
   parameter int INV_W         = 6
) (
   input  logic                frame_clk,
   input  logic                Reset,
   input  logic [9:0]          Bullet1X,
   input  logic [9:0]          Bullet1Y,
   input  logic [9:0]          Bullet1S,
   input  logic                bullet1_on,
   input  logic [9:0]          Bullet2X,
   input  logic [9:0]          Bullet2Y,
   input  logic [9:0]          Bullet2S,
   input  logic                bullet2_on,
   input  logic [9:0]          Tank1X,
   input  logic [9:0]          Tank1Y,
   input  logic [9:0]          Tank1S,
   input  logic [9:0]          Tank2X,
   input  logic [9:0]          Tank2Y,
   input  logic [9:0]          Tank2S,
   input  logic                armor1,
   input  logic                armor2,
   output logic                p1_player_hit,
   output logic                p2_player_hit,
   output logic                p1_armor_hit,
   output logic                p2_armor_hit,
   output logic                bullet_clash,
   output logic [HEALTH_W-1:0] health1,
   output logic [HEALTH_W-1:0] health2,
   output logic                invuln1,
   output logic                invuln2,
   output logic                game_over,
   output logic [1:0]          winner
);

   typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(START_HEALTH);
   localparam logic [INV_W-1:0]    INV_LOAD    = INV_W'(INVULN_FRAMES);

   state_t              state_q, state_d;
   logic [1:0]          winner_q, winner_d;
   logic [HEALTH_W-1:0] health1_q, health1_d, health2_q, health2_d;
   logic [INV_W-1:0]    inv1_q, inv1_d, inv2_q, inv2_d;
   logic                p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
   logic                p1_arm_q, p1_arm_d, p2_arm_q, p2_arm_d;
   logic                clash_q, clash_d;

   // Box overlap along one axis pair; widened so the sums can never wrap. Touching counts.
   function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                    input logic [9:0] asz, input logic [9:0] bx,
                                    input logic [9:0] by, input logic [9:0] bsz);
      logic [11:0] span;
      span = 12'(asz) + 12'(bsz);
      return (12'(ax) + span >= 12'(bx)) && (12'(bx) + span >= 12'(ax)) &&
             (12'(ay) + span >= 12'(by)) && (12'(by) + span >= 12'(ay));
   endfunction

   logic ov_b1b2, ov_b1t2, ov_b2t1;

   always_comb begin
      ov_b1b2 = overlap(Bullet1X, Bullet1Y, Bullet1S, Bullet2X, Bullet2Y, Bullet2S);
      ov_b1t2 = overlap(Bullet1X, Bullet1Y, Bullet1S, Tank2X, Tank2Y, Tank2S);
      ov_b2t1 = overlap(Bullet2X, Bullet2Y, Bullet2S, Tank1X, Tank1Y, Tank1S);
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      state_d   = state_q;
      winner_d  = winner_q;
      health1_d = health1_q;
      health2_d = health2_q;
      inv1_d    = (inv1_q != '0) ? inv1_q - 1'b1 : inv1_q;
      inv2_d    = (inv2_q != '0) ? inv2_q - 1'b1 : inv2_q;
      p1_hit_d  = 1'b0;
      p2_hit_d  = 1'b0;
      p1_arm_d  = 1'b0;
      p2_arm_d  = 1'b0;
      clash_d   = 1'b0;

      if (state_q == PLAY) begin
         if (bullet1_on && bullet2_on && ov_b1b2) begin
            clash_d = 1'b1;
         end else begin
            if (bullet1_on && ov_b1t2) begin
               if (armor2) begin
                  p1_arm_d = 1'b1;
               end else begin
                  p1_hit_d = 1'b1;
                  if (inv2_q == '0) begin
                     health2_d = (health2_q != '0) ? health2_q - 1'b1 : health2_q;
                     inv2_d    = INV_LOAD;
                  end
               end
            end
            if (bullet2_on && ov_b2t1) begin
               if (armor1) begin
                  p2_arm_d = 1'b1;
               end else begin
                  p2_hit_d = 1'b1;
                  if (inv1_q == '0) begin
                     health1_d = (health1_q != '0) ? health1_q - 1'b1 : health1_q;
                     inv1_d    = INV_LOAD;
                  end
               end
            end
         end

         if (health1_d == '0 || health2_d == '0) begin
            state_d = OVER;
            if (health1_d == '0 && health2_d == '0) winner_d = WIN_DRAW;
            else if (health2_d == '0)               winner_d = WIN_P1;
            else                                    winner_d = WIN_P2;
         end
      end
   end

   always_ff @(posedge frame_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (Reset) begin
         state_q   <= PLAY;
         winner_q  <= WIN_NONE;
         health1_q <= HEALTH_INIT;
         health2_q <= HEALTH_INIT;
         inv1_q    <= '0;
         inv2_q    <= '0;
         p1_hit_q  <= 1'b0;
         p2_hit_q  <= 1'b0;
         p1_arm_q  <= 1'b0;
         p2_arm_q  <= 1'b0;
         clash_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         winner_q  <= winner_d;
         health1_q <= health1_d;
         health2_q <= health2_d;
         inv1_q    <= inv1_d;
         inv2_q    <= inv2_d;
         p1_hit_q  <= p1_hit_d;
         p2_hit_q  <= p2_hit_d;
         p1_arm_q  <= p1_arm_d;
         p2_arm_q  <= p2_arm_d;
         clash_q   <= clash_d;
      end
   end

   assign p1_player_hit = p1_hit_q;
   assign p2_player_hit = p2_hit_q;
   assign p1_armor_hit  = p1_arm_q;
   assign p2_armor_hit  = p2_arm_q;
   assign bullet_clash  = clash_q;
   assign health1       = health1_q;
   assign health2       = health2_q;
   assign invuln1       = (inv1_q != '0);
   assign invuln2       = (inv2_q != '0);
   assign game_over     = (state_q == OVER);
   assign winner        = winner_q;

endmodule

// File: tb/tb_tank_hit_manager.sv
// Directed bench for tank_hit_manager: hit, immunity, armor, clash, edge-touch, draw and
// single-winner scenarios with hand-computed expectations.
module tb_tank_hit_manager;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [9:0] Bullet1X, Bullet1Y, Bullet1S, Bullet2X, Bullet2Y, Bullet2S;
   logic [9:0] Tank1X, Tank1Y, Tank1S, Tank2X, Tank2Y, Tank2S;
   logic       bullet1_on, bullet2_on, armor1, armor2;
   logic       p1_player_hit, p2_player_hit, p1_armor_hit, p2_armor_hit, bullet_clash;
   logic [1:0] health1, health2, winner;
   logic       invuln1, invuln2, game_over;

   int n_checks = 0;
   int n_errors = 0;

   tank_hit_manager dut (
      .frame_clk(frame_clk), .Reset(Reset),
      .Bullet1X(Bullet1X), .Bullet1Y(Bullet1Y), .Bullet1S(Bullet1S), .bullet1_on(bullet1_on),
      .Bullet2X(Bullet2X), .Bullet2Y(Bullet2Y), .Bullet2S(Bullet2S), .bullet2_on(bullet2_on),
      .Tank1X(Tank1X), .Tank1Y(Tank1Y), .Tank1S(Tank1S),
      .Tank2X(Tank2X), .Tank2Y(Tank2Y), .Tank2S(Tank2S),
      .armor1(armor1), .armor2(armor2),
      .p1_player_hit(p1_player_hit), .p2_player_hit(p2_player_hit),
      .p1_armor_hit(p1_armor_hit), .p2_armor_hit(p2_armor_hit), .bullet_clash(bullet_clash),
      .health1(health1), .health2(health2), .invuln1(invuln1), .invuln2(invuln2),
      .game_over(game_over), .winner(winner)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one frame and settle just after the edge.
   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic idle_inputs();
      bullet1_on = 1'b0; bullet2_on = 1'b0;
      Bullet1X = 10'd600; Bullet1Y = 10'd20; Bullet1S = 10'd2;
      Bullet2X = 10'd20;  Bullet2Y = 10'd450; Bullet2S = 10'd2;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   // One frame with the chosen bullets sitting on the opposing tank centres, then 60 quiet frames.
   task automatic hit_cycle(input logic b1, input logic b2);
      Bullet1X = Tank2X; Bullet1Y = Tank2Y; bullet1_on = b1;
      Bullet2X = Tank1X; Bullet2Y = Tank1Y; bullet2_on = b2;
      tick();
      idle_inputs();
      for (int i = 0; i < 60; i++) tick();
   endtask

   initial begin
      Tank1X = 10'd100; Tank1Y = 10'd100; Tank1S = 10'd8;
      Tank2X = 10'd400; Tank2Y = 10'd300; Tank2S = 10'd8;
      armor1 = 1'b0; armor2 = 1'b0;
      idle_inputs();
      do_reset();

      check("rst_health1", health1, 3);
      check("rst_health2", health2, 3);
      check("rst_winner", winner, 0);
      check("rst_game_over", game_over, 0);
      check("rst_strobes", {p1_player_hit, p2_player_hit, p1_armor_hit, p2_armor_hit, bullet_clash}, 0);
      check("rst_invuln", {invuln1, invuln2}, 0);

      // First hit at relative frame 0.
      Bullet1X = 10'd400; Bullet1Y = 10'd300; bullet1_on = 1'b1;
      tick();
      check("hit0_pulse", p1_player_hit, 1);
      check("hit0_health2", health2, 2);
      check("hit0_invuln2", invuln2, 1);
      check("hit0_p2_quiet", {p2_player_hit, p1_armor_hit, bullet_clash}, 0);

      for (int e = 1; e <= 70; e++) begin
         bullet1_on = (e == 10 || e == 70);
         tick();
         if (e == 1)  check("pulse_cleared", p1_player_hit, 0);
         if (e == 10) check("hit10_pulse", p1_player_hit, 1);
         if (e == 10) check("hit10_health2", health2, 2);
         if (e == 11) check("hit10_cleared", p1_player_hit, 0);
         if (e == 59) check("invuln_f59", invuln2, 1);
         if (e == 60) check("invuln_f60", invuln2, 0);
         if (e == 70) check("hit70_pulse", p1_player_hit, 1);
         if (e == 70) check("hit70_health2", health2, 1);
         if (e == 70) check("hit70_invuln2", invuln2, 1);
      end

      // Armor absorbs the bullet.
      armor2 = 1'b1; bullet1_on = 1'b1;
      tick();
      check("armor_pulse", p1_armor_hit, 1);
      check("armor_no_hit", p1_player_hit, 0);
      check("armor_health2", health2, 1);
      armor2 = 1'b0;

      // Bullets collide on top of Tank2: clash wins over the tank check.
      Bullet2X = 10'd401; Bullet2Y = 10'd300; bullet2_on = 1'b1;
      tick();
      check("clash_pulse", bullet_clash, 1);
      check("clash_no_hit", {p1_player_hit, p2_player_hit, p1_armor_hit, p2_armor_hit}, 0);
      check("clash_health2", health2, 1);
      idle_inputs();
      tick();
      check("clash_cleared", bullet_clash, 0);

      // Edge-touch geometry after a fresh reset.
      do_reset();
      Tank2X = 10'd110; Tank2Y = 10'd300;
      Bullet1X = 10'd99; Bullet1Y = 10'd300; bullet1_on = 1'b1;
      tick();
      check("miss_by_one", p1_player_hit, 0);
      Bullet1X = 10'd100;
      tick();
      check("touch_pulse", p1_player_hit, 1);
      check("touch_health2", health2, 2);

      // Own-tank overlap is ignored.
      Bullet1X = 10'd100; Bullet1Y = 10'd100;
      tick();
      check("own_tank", {p1_player_hit, p2_player_hit, p1_armor_hit}, 0);
      check("own_tank_health1", health1, 3);
      idle_inputs();

      // Draw: three simultaneous double hits, spaced past the immunity window.
      Tank2X = 10'd400; Tank2Y = 10'd300;
      do_reset();
      hit_cycle(1'b1, 1'b1);
      check("draw_step1", {health1, health2}, 4'b1010);
      hit_cycle(1'b1, 1'b1);
      check("draw_step2", {health1, health2}, 4'b0101);
      check("draw_not_over", game_over, 0);
      Bullet1X = Tank2X; Bullet1Y = Tank2Y; bullet1_on = 1'b1;
      Bullet2X = Tank1X; Bullet2Y = Tank1Y; bullet2_on = 1'b1;
      tick();
      check("draw_game_over", game_over, 1);
      check("draw_winner", winner, 2'b11);
      check("draw_health", {health1, health2}, 0);
      check("draw_final_pulses", {p1_player_hit, p2_player_hit}, 2'b11);
      tick();
      check("over_no_strobes", {p1_player_hit, p2_player_hit, p1_armor_hit, p2_armor_hit, bullet_clash}, 0);
      check("over_winner_frozen", winner, 2'b11);
      check("over_invuln_counting", {invuln1, invuln2}, 2'b11);
      idle_inputs();

      // Reset out of OVER.
      do_reset();
      check("rst_over_health", {health1, health2}, 4'b1111);
      check("rst_over_winner", winner, 0);
      check("rst_over_game_over", game_over, 0);

      // Only P1 scores: winner 01.
      hit_cycle(1'b1, 1'b0);
      hit_cycle(1'b1, 1'b0);
      hit_cycle(1'b1, 1'b0);
      check("p1_win_over", game_over, 1);
      check("p1_win_winner", winner, 2'b01);
      check("p1_win_health", {health1, health2}, 4'b1100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
